// File: rtl/decmuxadd_result_collector.sv
// Batch summariser for DecMuxAdd2 samples: saturating {Co,S} sum, max muxout, decout OR-mask, count.
// Optional decoder one-hot checker enabled by DECOUT_CHECK_EN.
module decmuxadd_result_collector #(
  parameter int BATCH_LEN = 8,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      decout,
  input  logic [3:0]       muxout,
  input  logic [3:0]       S,
  input  logic             Co,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [3:0]       out_max,
  output logic [15:0]      out_mask,
  output logic [7:0]       out_count,
  output logic             dec_err,
  output logic [7:0]       dec_err_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             sat, sat_nxt;
  logic [3:0]       mx, mx_nxt;
  logic [15:0]      mask, mask_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [ACC_W:0]   sum_w;
  logic             accept, take, close;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign sum_w     = {1'b0, acc} + {{(ACC_W-4){1'b0}}, Co, S};

  // Sample data only reaches the state through the accept-gated muxes, so X data with in_valid=0 is harmless.
  always_comb begin
    acc_nxt  = acc;
    sat_nxt  = sat;
    mx_nxt   = mx;
    mask_nxt = mask;
    cnt_nxt  = cnt;
    if (accept) begin
      acc_nxt  = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
      sat_nxt  = sat | sum_w[ACC_W];
      mx_nxt   = (muxout > mx) ? muxout : mx;
      mask_nxt = mask | decout;
      cnt_nxt  = cnt + 8'd1;
    end
    close = (state != HOLD) &&
            ((cnt_nxt == 8'(BATCH_LEN)) || (flush && (cnt_nxt != 8'd0)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (close) state_nxt = HOLD; else if (accept) state_nxt = ACCUM;
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (take)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      sat  <= 1'b0;
      mx   <= '0;
      mask <= '0;
      cnt  <= '0;
    end else if (take) begin
      acc  <= '0;
      sat  <= 1'b0;
      mx   <= '0;
      mask <= '0;
      cnt  <= '0;
    end else begin
      acc  <= acc_nxt;
      sat  <= sat_nxt;
      mx   <= mx_nxt;
      mask <= mask_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Summary registers load only on the closing edge, so they stay put through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_max   <= '0;
      out_mask  <= '0;
      out_count <= '0;
    end else if (close) begin
      out_sum   <= acc_nxt;
      out_sat   <= sat_nxt;
      out_max   <= mx_nxt;
      out_mask  <= mask_nxt;
      out_count <= cnt_nxt;
    end
  end

`ifdef DECOUT_CHECK_EN
  logic multi_hot;
  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_hot = |(decout & (decout - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_err     <= 1'b0;
      dec_err_cnt <= '0;
    end else if (accept && multi_hot) begin
      dec_err <= 1'b1;
      if (dec_err_cnt != 8'hFF) dec_err_cnt <= dec_err_cnt + 8'd1;
    end
  end
`else
  assign dec_err     = 1'b0;
  assign dec_err_cnt = '0;
`endif

endmodule

// File: tb/tb_decmuxadd_result_collector.sv
// Directed bench: three collector instances (BATCH_LEN 4 / 8 / 2, the last with ACC_W=5) sharing the sample bus.
module tb_decmuxadd_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] decout;
  logic [3:0]  muxout, S;
  logic        Co;
  logic [2:0]  v, fl, rdy;

  logic        a_ir, a_ov, a_sat, a_de;
  logic [15:0] a_sum, a_mask;
  logic [3:0]  a_max;
  logic [7:0]  a_cnt, a_dec;
  logic        b_ir, b_ov, b_sat, b_de;
  logic [15:0] b_sum, b_mask;
  logic [3:0]  b_max;
  logic [7:0]  b_cnt, b_dec;
  logic        c_ir, c_ov, c_sat, c_de;
  logic [4:0]  c_sum;
  logic [15:0] c_mask;
  logic [3:0]  c_max;
  logic [7:0]  c_cnt, c_dec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decmuxadd_result_collector #(.BATCH_LEN(4), .ACC_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(a_ir), .decout(decout),
    .muxout(muxout), .S(S), .Co(Co), .flush(fl[0]), .out_valid(a_ov), .out_ready(rdy[0]),
    .out_sum(a_sum), .out_sat(a_sat), .out_max(a_max), .out_mask(a_mask),
    .out_count(a_cnt), .dec_err(a_de), .dec_err_cnt(a_dec));

  decmuxadd_result_collector #(.BATCH_LEN(8), .ACC_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(b_ir), .decout(decout),
    .muxout(muxout), .S(S), .Co(Co), .flush(fl[1]), .out_valid(b_ov), .out_ready(rdy[1]),
    .out_sum(b_sum), .out_sat(b_sat), .out_max(b_max), .out_mask(b_mask),
    .out_count(b_cnt), .dec_err(b_de), .dec_err_cnt(b_dec));

  decmuxadd_result_collector #(.BATCH_LEN(2), .ACC_W(5)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_ready(c_ir), .decout(decout),
    .muxout(muxout), .S(S), .Co(Co), .flush(fl[2]), .out_valid(c_ov), .out_ready(rdy[2]),
    .out_sum(c_sum), .out_sat(c_sat), .out_max(c_max), .out_mask(c_mask),
    .out_count(c_cnt), .dec_err(c_de), .dec_err_cnt(c_dec));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample to instance `which` for one clock edge; returns on the following negedge.
  task automatic send(input int which, input logic [4:0] cs, input logic [3:0] mx, input logic [15:0] dc);
    Co = cs[4]; S = cs[3:0]; muxout = mx; decout = dc;
    v[which] = 1'b1;
    @(negedge clk);
    v[which] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; v = '0; fl = '0; rdy = 3'b111;
    decout = '0; muxout = '0; S = '0; Co = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out_sum",   a_sum, 0);
    chk("rst_out_mask",  a_mask, 0);
    chk("rst_out_count", a_cnt, 0);
    chk("rst_dec_err",   b_de, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", a_ir, 1);

    // basic batch of 4
    send(0, 5'd5,  4'd3, 16'h0001);
    send(0, 5'd31, 4'd9, 16'h0100);
    send(0, 5'd0,  4'd1, 16'h0000);
    send(0, 5'd12, 4'd9, 16'h0010);
    chk("basic_out_valid", a_ov, 1);
    chk("basic_sum",   a_sum, 48);
    chk("basic_max",   a_max, 9);
    chk("basic_mask",  a_mask, 16'h0111);
    chk("basic_count", a_cnt, 4);
    chk("basic_sat",   a_sat, 0);
    @(negedge clk);
    chk("basic_after_valid", a_ov, 0);
    chk("basic_after_ready", a_ir, 1);

    // backpressure
    rdy[0] = 1'b0;
    send(0, 5'd1, 4'd4, 16'h0002);
    send(0, 5'd2, 4'd2, 16'h0004);
    send(0, 5'd3, 4'd7, 16'h0008);
    send(0, 5'd4, 4'd1, 16'h0001);
    v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready",  a_ir, 0);
      chk("bp_out_valid", a_ov, 1);
      chk("bp_sum",       a_sum, 10);
      chk("bp_mask",      a_mask, 16'h000F);
      chk("bp_max",       a_max, 7);
      @(negedge clk);
    end
    v[0] = 1'b0; rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", a_ov, 0);
    chk("bp_release_ready", a_ir, 1);

    // flush a partial batch, then a flush with nothing pending
    send(1, 5'd7, 4'd2, 16'h0000);
    send(1, 5'd3, 4'd5, 16'h0000);
    fl[1] = 1'b1;
    @(negedge clk);
    fl[1] = 1'b0;
    chk("flush_valid", b_ov, 1);
    chk("flush_count", b_cnt, 2);
    chk("flush_sum",   b_sum, 10);
    chk("flush_max",   b_max, 5);
    @(negedge clk);
    chk("flush_handshake", b_ov, 0);
    fl[1] = 1'b1;
    @(negedge clk);
    fl[1] = 1'b0;
    chk("flush_empty_valid", b_ov, 0);
    @(negedge clk);
    chk("flush_empty_valid2", b_ov, 0);
    chk("flush_empty_ready",  b_ir, 1);

    // saturation with ACC_W=5
    send(2, 5'd31, 4'd0, 16'h0000);
    send(2, 5'd31, 4'd0, 16'h0000);
    chk("sat_valid", c_ov, 1);
    chk("sat_sum",   c_sum, 31);
    chk("sat_flag",  c_sat, 1);
    @(negedge clk);
    send(2, 5'd1, 4'd0, 16'h0000);
    send(2, 5'd2, 4'd0, 16'h0000);
    chk("sat2_sum",   c_sum, 3);
    chk("sat2_flag",  c_sat, 0);
    chk("sat2_count", c_cnt, 2);
    @(negedge clk);

    // asynchronous reset mid-batch
    send(0, 5'd9, 4'd3, 16'h0040);
    send(0, 5'd9, 4'd3, 16'h0040);
    send(0, 5'd9, 4'd3, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", a_ov, 0);
    chk("arst_sum",   a_sum, 0);
    chk("arst_mask",  a_mask, 0);
    chk("arst_count", a_cnt, 0);
    chk("arst_sat_c", c_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", a_ir, 1);
    send(0, 5'd1, 4'd1, 16'h0001);
    send(0, 5'd1, 4'd1, 16'h0001);
    send(0, 5'd1, 4'd1, 16'h0001);
    send(0, 5'd1, 4'd1, 16'h0001);
    chk("arst_clean_valid", a_ov, 1);
    chk("arst_clean_count", a_cnt, 4);
    chk("arst_clean_sum",   a_sum, 4);
    chk("arst_clean_mask",  a_mask, 16'h0001);
    @(negedge clk);

    // decoder one-hot checker
    send(1, 5'd0, 4'd0, 16'h0003);
    send(1, 5'd0, 4'd0, 16'h0000);
    send(1, 5'd0, 4'd0, 16'h8001);
    fl[1] = 1'b1;
    @(negedge clk);
    fl[1] = 1'b0;
    chk("dec_mask",  b_mask, 16'h8003);
    chk("dec_count", b_cnt, 3);
`ifdef DECOUT_CHECK_EN
    chk("dec_err",     b_de, 1);
    chk("dec_err_cnt", b_dec, 2);
`else
    chk("dec_err",     b_de, 0);
    chk("dec_err_cnt", b_dec, 0);
`endif
    chk("dec_err_other", a_de, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
